// File: rtl/apb_master_bridge_mc.sv
// apb_master_bridge_mc
// Single-outstanding APB4 master bridge for 1..16 slaves. One request is
// accepted in IDLE, run as a SETUP/ACCESS transfer to the slave decoded from
// the top address bits, and answered with a one-cycle response pulse.
// Optional feature: define APB_MASTER_TIMEOUT_EN to bound the ACCESS wait
// states to TIMEOUT_CYCLES; without it ACCESS waits for PREADY indefinitely.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SETUP  | PSEL of the decoded slave high, PENABLE low
// ACCESS | PSEL and PENABLE high, waiting for the selected PREADY
// RESP   | bus released, rsp_valid high for this single cycle
module apb_master_bridge_mc #(
   parameter int ADDR_WIDTH     = 9,
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_SLAVES     = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             PCLK,
   input  logic                             PRESETn,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_write,
   input  logic [ADDR_WIDTH-1:0]            req_addr,
   input  logic [DATA_WIDTH-1:0]            req_wdata,
   input  logic [DATA_WIDTH/8-1:0]          req_strb,
   output logic                             rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             rsp_err,
   output logic [NUM_SLAVES-1:0]            PSEL,
   output logic                             PENABLE,
   output logic [ADDR_WIDTH-1:0]            PADDR,
   output logic                             PWRITE,
   output logic [DATA_WIDTH-1:0]            PWDATA,
   output logic [DATA_WIDTH/8-1:0]          PSTRB,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]            PREADY,
   input  logic [NUM_SLAVES-1:0]            PSLVERR
);

   localparam int SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 0;
   // Index registers need at least one bit even for a single slave.
   localparam int IDX_W    = (SEL_BITS > 0) ? SEL_BITS : 1;
   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam logic [IDX_W:0] NUM_SLAVES_L = (IDX_W + 1)'(NUM_SLAVES);

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                  r_state;
   logic [IDX_W-1:0]        r_idx;
   logic [NUM_SLAVES-1:0]   r_psel;
   logic                    r_penable;
   logic [ADDR_WIDTH-1:0]   r_paddr;
   logic                    r_pwrite;
   logic [DATA_WIDTH-1:0]   r_pwdata;
   logic [STRB_W-1:0]       r_pstrb;
   logic                    r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;
   logic                    r_rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
   logic [CNT_W-1:0]        r_tmo_cnt;
`endif

   logic [IDX_W-1:0]        w_req_idx;
   logic                    w_req_idx_ok;
   logic [NUM_SLAVES-1:0]   w_psel_dec;
   logic                    w_pready;
   logic                    w_pslverr;
   logic [DATA_WIDTH-1:0]   w_prdata;

   // With one slave there are no select bits and every address maps to slave 0.
   generate
      if (SEL_BITS > 0) begin : g_idx
         assign w_req_idx = req_addr[ADDR_WIDTH-1 -: SEL_BITS];
      end else begin : g_idx_single
         assign w_req_idx = '0;
      end
   endgenerate

   // Indices at or above NUM_SLAVES only exist for non-power-of-2 slave counts.
   assign w_req_idx_ok = ({1'b0, w_req_idx} < NUM_SLAVES_L);

   assign req_ready = (r_state == S_IDLE);

   // Decode the one-hot select for the incoming request and mux the responding
   // slave's inputs by the captured index; other slaves are never looked at.
   always_comb begin
      w_psel_dec = '0;
      w_pready   = 1'b0;
      w_pslverr  = 1'b0;
      w_prdata   = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (w_req_idx == IDX_W'(i)) begin
            w_psel_dec[i] = 1'b1;
         end
         if (r_idx == IDX_W'(i)) begin
            w_pready  = PREADY[i];
            w_pslverr = PSLVERR[i];
            w_prdata  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Transfer sequencer; every bus and response output is a register here.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_psel      <= '0;
         r_penable   <= 1'b0;
         r_paddr     <= '0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= '0;
         r_pstrb     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         r_tmo_cnt   <= '0;
`endif
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  if (w_req_idx_ok) begin
                     r_idx    <= w_req_idx;
                     r_psel   <= w_psel_dec;
                     r_paddr  <= req_addr;
                     r_pwrite <= req_write;
                     r_pwdata <= req_wdata;
                     r_pstrb  <= req_write ? req_strb : '0;
                     r_state  <= S_SETUP;
                  end else begin
                     // Decode error: bus stays untouched, answer next cycle.
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                     r_state     <= S_RESP;
                  end
               end
            end
            S_SETUP: begin
               r_penable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
               r_tmo_cnt <= '0;
`endif
               r_state   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (w_pready) begin
                  r_psel      <= '0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_pslverr;
                  r_rsp_rdata <= (!r_pwrite && !w_pslverr) ? w_prdata : '0;
                  r_state     <= S_RESP;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (r_tmo_cnt == TMO_LAST) begin
                  // Last allowed wait state with PREADY still low.
                  r_psel      <= '0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_rdata <= '0;
                  r_state     <= S_RESP;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
`endif
            end
            S_RESP: begin
               r_rsp_err   <= 1'b0;
               r_rsp_rdata <= '0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;
   assign PADDR     = r_paddr;
   assign PWRITE    = r_pwrite;
   assign PWDATA    = r_pwdata;
   assign PSTRB     = r_pstrb;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge_mc.sv
// Bench for apb_master_bridge_mc: 3 slaves, 32-bit data, 9-bit address.
// A driver issues requests and pushes the expected response; a monitor pops
// and compares on every rsp_valid and also checks the APB bus each cycle.
module tb_apb_master_bridge_mc;
   localparam int AW  = 9;
   localparam int DW  = 32;
   localparam int NS  = 3;
   localparam int SW  = DW / 8;
   localparam int TMO = 16;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_write = 1'b0;
   logic [AW-1:0]    req_addr = '0;
   logic [DW-1:0]    req_wdata = '0;
   logic [SW-1:0]    req_strb = '0;
   logic             rsp_valid;
   logic [DW-1:0]    rsp_rdata;
   logic             rsp_err;
   logic [NS-1:0]    PSEL;
   logic             PENABLE;
   logic [AW-1:0]    PADDR;
   logic             PWRITE;
   logic [DW-1:0]    PWDATA;
   logic [SW-1:0]    PSTRB;
   logic [NS*DW-1:0] PRDATA = '0;
   logic [NS-1:0]    PREADY = '0;
   logic [NS-1:0]    PSLVERR = '0;

   apb_master_bridge_mc #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .PCLK(clk), .PRESETn(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            lat;   // cycles from acceptance edge to response, = cycles PSEL is high
      int            acc;
   } exp_t;
   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;

   // current transfer, as the slaves and the bus monitor should see it
   int            plan_w = 0;
   logic [DW-1:0] plan_rd = '0;
   logic          plan_err = 1'b0;
   logic [AW-1:0] cur_addr = '0;
   logic          cur_wr = 1'b0;
   logic [DW-1:0] cur_wd = '0;
   logic [SW-1:0] cur_strb = '0;
   int            cur_idx = 0;

   int acc_n = 0;
   int psel_run = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, expv, $time);
      end
   endtask

   // Issue one request; expectation comes from the bridge's documented rules.
   task automatic do_req(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st, input int w, input logic [DW-1:0] rd,
                         input bit serr, input bit expect_rsp);
      exp_t e;
      int   idx;
      int   n;
      idx = int'(addr[AW-1 -: 2]);
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check("req_ready_wait", 64'(req_ready), 64'd1);
         return;
      end
      plan_w   = w;
      plan_rd  = rd;
      plan_err = serr;
      cur_addr = addr;
      cur_wr   = wr;
      cur_wd   = wd;
      cur_strb = st;
      cur_idx  = idx;
      if (expect_rsp) begin
         if (idx >= NS) begin
            e.rdata = '0; e.err = 1'b1; e.lat = 0;
         end else if (TMO_EN && w >= TMO) begin
            e.rdata = '0; e.err = 1'b1; e.lat = 1 + TMO;
         end else begin
            e.err   = serr;
            e.rdata = (!wr && !serr) ? rd : '0;
            e.lat   = 2 + w;
         end
         e.acc = cyc + 1;
         exp_q.push_back(e);
      end
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_strb  = st;
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = $urandom;
      req_strb  = SW'($urandom);
   endtask

   // Slave models: junk on every slave, the selected one answers per plan.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < NS; i++) begin
            PREADY[i]          = 1'($urandom);
            PSLVERR[i]         = 1'($urandom);
            PRDATA[i*DW +: DW] = $urandom;
         end
         if (PENABLE) begin
            for (int i = 0; i < NS; i++) begin
               if (PSEL[i]) begin
                  PREADY[i] = (acc_n >= plan_w);
                  if (acc_n >= plan_w) begin
                     PRDATA[i*DW +: DW] = plan_rd;
                     PSLVERR[i]         = plan_err;
                  end
               end
            end
            acc_n++;
         end else begin
            acc_n = 0;
         end
      end
   end

   // Monitor: bus protocol each cycle, scoreboard pop on each response.
   initial begin
      exp_t          e;
      logic [NS-1:0] oh;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            psel_run = 0;
         end else begin
            if (PSEL != '0) begin
               oh = '0;
               for (int i = 0; i < NS; i++) if (i == cur_idx) oh[i] = 1'b1;
               check("psel_onehot", 64'(PSEL), 64'(oh));
               check("penable_phase", 64'(PENABLE), 64'(psel_run > 0));
               check("paddr", 64'(PADDR), 64'(cur_addr));
               check("pwrite", 64'(PWRITE), 64'(cur_wr));
               check("pstrb", 64'(PSTRB), cur_wr ? 64'(cur_strb) : 64'd0);
               if (cur_wr) check("pwdata", 64'(PWDATA), 64'(cur_wd));
               psel_run++;
            end else begin
               check("penable_idle", 64'(PENABLE), 64'd0);
            end
            if (rsp_valid) begin
               if (exp_q.size() == 0) begin
                  check("rsp_unexpected", 64'(rsp_valid), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                  check("rsp_err", 64'(rsp_err), 64'(e.err));
                  check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                  check("psel_cycles", 64'(psel_run), 64'(e.lat));
                  check("psel_in_rsp", 64'(PSEL), 64'd0);
               end
               psel_run = 0;
            end
         end
      end
   end

   task automatic reset_mid_access();
      int n;
      do_req(1'b0, 9'h008, '0, '0, 1000, 32'h0, 1'b0, 1'b0);
      n = 0;
      while (!PENABLE && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("reset_reach_access", 64'(PENABLE), 64'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("reset_psel", 64'(PSEL), 64'd0);
      check("reset_penable", 64'(PENABLE), 64'd0);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_after_reset", 64'(req_ready), 64'd1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      bit            wr;
      logic [AW-1:0] a;
      int            w;
      int            n;
      repeat (3) @(negedge clk);
      check("rst_psel", 64'(PSEL), 64'd0);
      check("rst_penable", 64'(PENABLE), 64'd0);
      check("rst_bus", {PADDR, PWRITE, PSTRB, PWDATA}, 64'd0);
      check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_out_of_reset", 64'(req_ready), 64'd1);

      do_req(1'b1, 9'h0A4, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 1'b1);
      do_req(1'b0, 9'h004, 32'h0, 4'h0, 3, 32'h12345678, 1'b0, 1'b1);
      do_req(1'b0, 9'h1A4, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0, 1'b1);
      do_req(1'b1, 9'h104, 32'h5555AAAA, 4'h3, 0, 32'h0, 1'b1, 1'b1);
`ifdef APB_MASTER_TIMEOUT_EN
      do_req(1'b0, 9'h010, 32'h0, 4'h0, 1000, 32'h11111111, 1'b0, 1'b1);
      do_req(1'b0, 9'h014, 32'h0, 4'h0, TMO - 1, 32'h22222222, 1'b0, 1'b1);
      do_req(1'b0, 9'h018, 32'h0, 4'h0, 1, 32'h33333333, 1'b0, 1'b1);
`endif
      reset_mid_access();

      for (int k = 0; k < 60; k++) begin
         wr = 1'($urandom);
         a  = AW'($urandom);
         w  = $urandom_range(0, 4);
         if ($urandom_range(0, 7) == 0) w = TMO_EN ? (TMO - 1 + $urandom_range(0, 2)) : 15;
         do_req(wr, a, $urandom, SW'($urandom), w, $urandom, ($urandom_range(0, 3) == 0), 1'b1);
      end

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
